// File: rtl/image_capture_writer.sv
`timescale 1ns/1ps
// image_capture_writer
//   Samples an 8-bit pixel stream inside the centred image window and packs
//   the pixels into DRAM_DATA_WIDTH-bit words. Words go through a small
//   {addr,data} FIFO to the DRAM controller write port. The frame layout
//   matches the DRAM-fed image sender, so captured frames replay unchanged.
//
// Ports
//   clk_pixel, image_capture_reset_n     clock / async active-low reset
//   capture_arm, capture_base_addr       request a capture of the next frame
//   cx, cy, pixel_in                     raster position and pixel value
//   image_width, image_height            window size (latched on arm)
//   dram_write_*                         DRAM controller write interface
//   capture_busy, capture_done           capture status
//   capture_overflow, capture_word_count sticky drop flag / pushes this frame
//
// Optional feature: define IMAGE_CAPTURE_THRESHOLD_EN to add the input
//   capture_threshold; each sampled pixel is then stored as 8'hFF when
//   pixel_in >= capture_threshold and 8'h00 otherwise.
module image_capture_writer #(
  parameter int SCREEN_WIDTH    = 1920,
  parameter int SCREEN_HEIGHT   = 1080,
  parameter int BIT_WIDTH       = 12,
  parameter int BIT_HEIGHT      = 11,
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int DRAM_ADDR_WIDTH = 39,
  parameter int WORD_FIFO_DEPTH = 16
) (
  input  logic                       clk_pixel,
  input  logic                       image_capture_reset_n,
  input  logic                       capture_arm,
  input  logic [DRAM_ADDR_WIDTH-1:0] capture_base_addr,
  input  logic [BIT_WIDTH-1:0]       cx,
  input  logic [BIT_HEIGHT-1:0]      cy,
  input  logic [7:0]                 pixel_in,
  input  logic [BIT_WIDTH-1:0]       image_width,
  input  logic [BIT_HEIGHT-1:0]      image_height,
`ifdef IMAGE_CAPTURE_THRESHOLD_EN
  input  logic [7:0]                 capture_threshold,
`endif
  output logic [DRAM_ADDR_WIDTH-1:0] dram_write_addr,
  output logic [7:0]                 dram_write_len,
  output logic                       dram_write_en,
  output logic [DRAM_DATA_WIDTH-1:0] dram_write_data,
  input  logic                       dram_write_busy,
  output logic                       capture_busy,
  output logic                       capture_done,
  output logic                       capture_overflow,
  output logic [15:0]                capture_word_count
);
  localparam int PIX_PER_WORD = DRAM_DATA_WIDTH / 8;
  localparam int KW = $clog2(PIX_PER_WORD);
  localparam int FW = $clog2(WORD_FIFO_DEPTH);
  localparam logic [DRAM_ADDR_WIDTH-1:0] WORD_BYTES = DRAM_ADDR_WIDTH'(PIX_PER_WORD);

  localparam logic [2:0] S_IDLE = 3'd0, S_ARMED = 3'd1, S_CAPT = 3'd2,
                         S_FLUSH = 3'd3, S_DONE = 3'd4;
  localparam logic [1:0] W_IDLE = 2'd0, W_ISSUE = 2'd1, W_HOLD = 2'd2;

  logic [2:0]                 cst_q, cst_d;
  logic [1:0]                 wst_q, wst_d;
  logic [BIT_WIDTH-1:0]       w_q;
  logic [BIT_HEIGHT-1:0]      h_q;
  logic [DRAM_ADDR_WIDTH-1:0] addr_q;
  logic [KW-1:0]              k_q;
  logic [DRAM_DATA_WIDTH-1:0] pack_q, pack_ins;
  logic                       ovf_q;
  logic [15:0]                cnt_q;
  logic [FW-1:0]              wp_q, rp_q;
  logic [FW:0]                fcnt_q;
  logic [DRAM_ADDR_WIDTH-1:0] fa_mem [WORD_FIFO_DEPTH];
  logic [DRAM_DATA_WIDTH-1:0] fd_mem [WORD_FIFO_DEPTH];

  // Window bounds, one bit wider than the coordinates so the upper bound of a
  // full-screen window is representable.
  logic [BIT_WIDTH:0]  x_lo, x_hi;
  logic [BIT_HEIGHT:0] y_lo, y_hi;
  assign x_lo = (BIT_WIDTH+1)'(SCREEN_WIDTH/2) - (BIT_WIDTH+1)'(w_q >> 1);
  assign x_hi = (BIT_WIDTH+1)'(SCREEN_WIDTH/2) + (BIT_WIDTH+1)'(w_q >> 1)
              + (BIT_WIDTH+1)'(w_q[0]);
  assign y_lo = (BIT_HEIGHT+1)'(SCREEN_HEIGHT/2) - (BIT_HEIGHT+1)'(h_q >> 1);
  assign y_hi = (BIT_HEIGHT+1)'(SCREEN_HEIGHT/2) + (BIT_HEIGHT+1)'(h_q >> 1)
              + (BIT_HEIGHT+1)'(h_q[0]);

  logic in_win, frame_start, frame_end, arm_acc, sample, word_full, flush_part;
  logic push, pop, push_ok, fifo_full, fifo_empty;
  logic [7:0] pix_val;

  assign in_win = ({1'b0, cx} >= x_lo) && ({1'b0, cx} < x_hi) &&
                  ({1'b0, cy} >= y_lo) && ({1'b0, cy} < y_hi);
  assign frame_start = (cx == '0) && (cy == '0);
  assign frame_end   = (cx == '0) && ({1'b0, cy} == y_hi);
  assign arm_acc     = (cst_q == S_IDLE) && capture_arm;
  assign sample      = in_win && (((cst_q == S_ARMED) && frame_start) || (cst_q == S_CAPT));
  assign word_full   = sample && (k_q == KW'(PIX_PER_WORD - 1));
  // y_end lies outside the window, so no pixel is sampled in the flush cycle.
  assign flush_part  = (cst_q == S_CAPT) && frame_end && (k_q != '0);
  assign push        = word_full || flush_part;

`ifdef IMAGE_CAPTURE_THRESHOLD_EN
  assign pix_val = (pixel_in >= capture_threshold) ? 8'hFF : 8'h00;
`else
  assign pix_val = pixel_in;
`endif

  always_comb begin
    pack_ins = pack_q;
    pack_ins[{k_q, 3'b000} +: 8] = pix_val;
  end

  // FIFO: a pop frees a slot in the same cycle, so full+pop still accepts a push.
  assign fifo_full  = (fcnt_q == (FW+1)'(WORD_FIFO_DEPTH));
  assign fifo_empty = (fcnt_q == '0);
  assign pop        = (wst_q == W_ISSUE);
  assign push_ok    = push && (!fifo_full || pop);

  always_ff @(posedge clk_pixel) begin
    if (push_ok) begin
      fa_mem[wp_q] <= addr_q;
      fd_mem[wp_q] <= word_full ? pack_ins : pack_q;
    end
  end

  always_ff @(posedge clk_pixel or negedge image_capture_reset_n) begin
    if (!image_capture_reset_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      fcnt_q <= '0;
    end else begin
      if (push_ok) wp_q <= wp_q + FW'(1);
      if (pop)     rp_q <= rp_q + FW'(1);
      case ({push_ok, pop})
        2'b10:   fcnt_q <= fcnt_q + (FW+1)'(1);
        2'b01:   fcnt_q <= fcnt_q - (FW+1)'(1);
        default: fcnt_q <= fcnt_q;
      endcase
    end
  end

  always_comb begin
    cst_d = cst_q;
    case (cst_q)
      S_IDLE:  if (capture_arm) cst_d = S_ARMED;
      S_ARMED: if (frame_start) cst_d = S_CAPT;
      S_CAPT:  if (frame_end)   cst_d = S_FLUSH;
      S_FLUSH: if (fifo_empty && (wst_q == W_IDLE)) cst_d = S_DONE;
      S_DONE:  cst_d = S_IDLE;
      default: cst_d = S_IDLE;
    endcase
  end

  always_comb begin
    wst_d = wst_q;
    case (wst_q)
      W_IDLE:  if (!fifo_empty && !dram_write_busy) wst_d = W_ISSUE;
      W_ISSUE: wst_d = W_HOLD;
      W_HOLD:  if (!dram_write_busy) wst_d = W_IDLE;
      default: wst_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_pixel or negedge image_capture_reset_n) begin
    if (!image_capture_reset_n) begin
      cst_q  <= S_IDLE;
      wst_q  <= W_IDLE;
      w_q    <= '0;
      h_q    <= '0;
      addr_q <= '0;
      k_q    <= '0;
      pack_q <= '0;
      ovf_q  <= 1'b0;
      cnt_q  <= '0;
    end else begin
      cst_q <= cst_d;
      wst_q <= wst_d;
      if (arm_acc) begin
        w_q    <= image_width;
        h_q    <= image_height;
        addr_q <= capture_base_addr;
        k_q    <= '0;
        pack_q <= '0;
        ovf_q  <= 1'b0;
        cnt_q  <= '0;
      end else begin
        if (sample) begin
          k_q    <= k_q + KW'(1);
          pack_q <= word_full ? '0 : pack_ins;
        end
        if (flush_part) begin
          k_q    <= '0;
          pack_q <= '0;
        end
        // Address advances on every attempted push, so words after a drop
        // still land at their own slot.
        if (push) begin
          addr_q <= addr_q + WORD_BYTES;
          cnt_q  <= cnt_q + 16'd1;
          if (!push_ok) ovf_q <= 1'b1;
        end
      end
    end
  end

  assign dram_write_en      = (wst_q == W_ISSUE);
  assign dram_write_addr    = dram_write_en ? fa_mem[rp_q] : '0;
  assign dram_write_data    = dram_write_en ? fd_mem[rp_q] : '0;
  assign dram_write_len     = 8'd0;
  assign capture_busy       = (cst_q == S_ARMED) || (cst_q == S_CAPT) || (cst_q == S_FLUSH);
  assign capture_done       = (cst_q == S_DONE);
  assign capture_overflow   = ovf_q;
  assign capture_word_count = cnt_q;
endmodule

// File: doc/image_capture_writer.md
Name: image_capture_writer

Overview:
- Write-direction counterpart of the DRAM-fed image sender in the photonic display path.
- Samples an 8-bit pixel stream against the same centred image window (cx/cy timing) and packs pixels into DRAM_DATA_WIDTH-bit words.
- Writes the words to DRAM through the dram_write_* interface of the DRAM controller.
- Captured frames are laid out exactly as the sender reads them back, so a camera or loopback frame can be replayed unchanged.

Parameters:
- SCREEN_WIDTH, 1920, active pixels per line.
- SCREEN_HEIGHT, 1080, active lines per frame.
- BIT_WIDTH, 12, width of cx and image_width.
- BIT_HEIGHT, 11, width of cy and image_height.
- DRAM_DATA_WIDTH, 512, DRAM word width; PIX_PER_WORD = DRAM_DATA_WIDTH/8.
- DRAM_ADDR_WIDTH, 39, DRAM byte-address width.
- WORD_FIFO_DEPTH, 16, entries of the internal {addr,data} FIFO (power of 2).

Ports:
- clk_pixel  in  1  pixel clock; the only clock.
- image_capture_reset_n  in  1  asynchronous active-low reset.
- capture_arm  in  1  one-cycle request to capture the next frame.
- capture_base_addr  in  DRAM_ADDR_WIDTH  byte address of the first word; latched on arm.
- cx  in  BIT_WIDTH  current x coordinate.
- cy  in  BIT_HEIGHT  current y coordinate.
- pixel_in  in  8  pixel value aligned with cx/cy.
- image_width  in  BIT_WIDTH  window width; latched on arm.
- image_height  in  BIT_HEIGHT  window height; latched on arm.
- dram_write_addr  out  DRAM_ADDR_WIDTH  write byte address.
- dram_write_len  out  8  burst length minus 1; always 0.
- dram_write_en  out  1  one-cycle write request.
- dram_write_data  out  DRAM_DATA_WIDTH  write data.
- dram_write_busy  in  1  controller busy.
- capture_busy  out  1  high from arm accept until done.
- capture_done  out  1  one-cycle pulse when the frame is fully written.
- capture_overflow  out  1  sticky: a word was dropped; cleared on next accepted arm.
- capture_word_count  out  16  words pushed this frame.

Behaviour:
- Reset (async assert, sync release): all outputs 0, FIFO empty, both FSMs idle. Reset mid-write drops dram_write_en immediately; pending words are discarded.
- Window, same rule as the sender:
  - x in [SW/2 - w/2, SW/2 + w/2 + w[0]).
  - y in [SH/2 - h/2, SH/2 + h/2 + h[0]).
  - Evaluated on the cx/cy presented in the same cycle.
- Capture FSM states: IDLE, ARMED, CAPTURE, FLUSH, DONE.
  - IDLE -> ARMED on capture_arm. Latches base, width and height; clears overflow and word count. Arm in any other state is ignored.
  - ARMED -> CAPTURE on cx==0 && cy==0. That cycle's pixel is sampled if it lies in the window.
  - CAPTURE: each in-window pixel is written to byte lane k of the pack register, bits [8k+7:8k], where k counts 0..PIX_PER_WORD-1. When k wraps, the word is pushed with addr = base + n*(DRAM_DATA_WIDTH/8) and n increments.
  - CAPTURE -> FLUSH on cx==0 && cy==y_end (y_end = first line past the window). If k!=0, the partial word is pushed with the unused upper bytes zero.
  - FLUSH -> DONE when the FIFO is empty and the write FSM is idle.
  - DONE: capture_done=1 for one cycle, then IDLE.
- Zero-size window (w==0 or h==0): no words pushed; done issues in the cycle after the CAPTURE->FLUSH transition.
- Overflow: a push while the FIFO is full drops the word and sets capture_overflow. n still increments, so later words keep their correct addresses. capture_word_count counts pushes attempted.
- Write FSM states: W_IDLE, W_ISSUE, W_HOLD.
  - W_IDLE -> W_ISSUE when the FIFO is non-empty and dram_write_busy==0.
  - W_ISSUE: drives addr and data from the FIFO head, dram_write_en=1 for exactly one cycle, len=0, and pops the FIFO.
  - W_HOLD: waits at least one cycle, then until dram_write_busy==0, then returns to W_IDLE.
  - Minimum spacing between write enables is 3 cycles.
- Simultaneous FIFO push and pop in one cycle are both honoured; a full FIFO with a concurrent pop accepts the push.
- All addresses are DRAM_ADDR_WIDTH wide and wrap modulo 2^DRAM_ADDR_WIDTH; no clamping.

Optional Feature:
- Macro IMAGE_CAPTURE_THRESHOLD_EN.
- Defined: adds input capture_threshold[7:0]. Each sampled pixel is stored as 8'hFF if pixel_in >= capture_threshold, else 8'h00 (binary mask capture). The comparison is combinational in the sample cycle, so latency is unchanged.
- Undefined: the port is absent and pixel_in is stored unmodified.

Test Plan:
- 64x2 window:
  - Stimulus: base=0x1000, ramp pixel = cx[7:0], dram_write_busy tied 0.
  - Response: 2 writes, to 0x1000 and 0x1040. Byte k of each word = SW/2-32+k. capture_done pulses once; count=2.
- 3x3 window (odd size):
  - Stimulus: base=0.
  - Response: captured x = 959..961 and y = 539..541. One write at addr 0 with bytes 0..8 set and bytes 9..63 zero.
- Busy held high for 200 cycles, 64x16 window:
  - Response: no writes while busy. Words drain afterwards in address order with enables ≥3 cycles apart. No overflow: the window produces 16 words, within the FIFO depth of 16.
- Overflow:
  - Stimulus: busy held high for a whole 1920x8 capture.
  - Response: capture_overflow=1 and count=240. Written addresses are a subset of base + n*64, and each written word's data matches its own address.
- Arm during CAPTURE is ignored. Async reset asserted mid-burst: dram_write_en=0 at once, then IDLE, and a new arm captures the next frame correctly.
- IMAGE_CAPTURE_THRESHOLD_EN:
  - Stimulus: threshold=0x80, ramp input.
  - Response: bytes 0x00 for pixels 0..127 and 0xFF for pixels 128..255.
